fetch_predict_stage: RTL and testbench
======================================

# fetch_predict_stage

Instruction-fetch stage of the pipelined RV32I core: owns the PC register, a direct-mapped branch predictor (2-bit BHT + BTB), and the IF/ID pipeline register that produces `InstrD`, `PCD`, `PCPlus4D` for the decode stage. It is the producer end of the decode stage's input interface. Execute-stage resolution feeds back into it for predictor training and misprediction redirect.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset
- `IDX_W`, 6, predictor index width; 2^IDX_W entries; tag width = 30-IDX_W
- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  reset: synchronous and active-low
- `PCF`  out  32  current fetch PC, to instruction memory
- `InstrF`  in  32  instruction read combinationally at `PCF`
- `StallF`  in  1  hold PC register
- `StallD`  in  1  hold IF/ID register
- `FlushD`  in  1  clear IF/ID register (bubble)
- `UpdateE`  in  1  branch/jump resolved in EX this cycle; train predictor
- `UpdatePCE`  in  32  PC of resolved instruction
- `UpdateTakenE`  in  1  actual direction (1 for jal/jalr)
- `UpdateTargetE`  in  32  actual target address
- `RedirectE`  in  1  misprediction detected; load `RedirectPCE`
- `RedirectPCE`  in  32  correct next PC
- `InstrD`, `PCD`, `PCPlus4D`  out  32 each  IF/ID register outputs
- `PredTakenD`  out  1  prediction made for the instruction now in D
- `PredTargetD`  out  32  predicted next PC for the instruction now in D

## Operation
- Index = `PCF[IDX_W+1:2]`; tag = `PCF[31:IDX_W+2]`.
- Per entry: 2-bit saturating counter, BTB valid bit, tag, 32-bit target.
- Prediction (combinational): hit = valid & tag match; predict taken iff hit and counter >= 2'b10; predicted next PC = taken ? BTB target : `PCF`+4.
- Next-PC priority: `RedirectE` -> `RedirectPCE`; else `StallF` -> hold; else predicted next PC.
- Training on `UpdateE`, entry indexed by `UpdatePCE`:
  - counter +1 saturating at 3 if `UpdateTakenE`, else -1 saturating at 0;
  - if `UpdateTakenE`: write tag, target = `UpdateTargetE`, valid = 1;
  - not-taken leaves BTB contents untouched.
- IF/ID register priority: `FlushD` -> all outputs 0; else `StallD` -> hold; else capture `InstrF`, `PCF`, `PCF`+4, prediction bit, predicted next PC.
- `FlushD` overrides `StallD`. `RedirectE` does not flush D by itself; the hazard unit asserts `FlushD` alongside.
- All adds are 32-bit modulo: `PCF`=FFFF_FFFC gives `PCPlus4D`=0000_0000.

## Timing
- Reset, cycle after `rst`=0 sampled:
  - `PCF`=`RESET_PC`;
  - IF/ID outputs, `PredTakenD`, `PredTargetD` all 0;
  - every counter 2'b01 (weakly not-taken), every valid bit 0.
- Reset asserted mid-operation overrides redirect, stall, flush, and training in that same cycle.
- Fetch-to-decode latency: 1 cycle. Redirect takes effect on `PCF` the cycle after `RedirectE`.
- Same-cycle training and lookup on the same index: the lookup sees pre-update state; the new state is visible next cycle.
- Training proceeds regardless of `StallF`, `StallD`, and `FlushD`.
- No backpressure handshake; stall and flush levels are sampled every edge.

## Structure
- Shared package: `IDX_W` default, counter encodings (SNT=0, WNT=1, WT=2, ST=3), `NOP_INSTR`, reset counter value.
- Sub-module `branch_predictor`:
  - holds BHT + BTB in flops, so a single-cycle reset clears them;
  - one combinational lookup port, one synchronous update port.
- Top level holds the PC register, next-PC mux, and IF/ID register.

## Test plan
- Reset: hold `rst`=0 two cycles, `RESET_PC`=0x100 -> `PCF`=0x100, `InstrD`=0, `PredTakenD`=0; next cycles `PCF`=0x104, 0x108.
- Training: `UpdateE` twice, PC 0x40 taken to 0x80 -> counter 1->2->3, valid; later `PCF`=0x40 gives next `PCF`=0x80, `PredTakenD`=1, `PredTargetD`=0x80.
- Saturation and hysteresis: one not-taken update on that entry -> counter 2, still predicts 0x80; second -> counter 1, next PC 0x44.
- Redirect precedence: `RedirectE`=1 with `RedirectPCE`=0x200 and `StallF`=1 in the same cycle -> `PCF`=0x200 next cycle.
- Stall/flush: `StallD`=1 holds `InstrD` for 3 cycles; `FlushD` and `StallD` together -> `InstrD`=`PCD`=`PCPlus4D`=0.
- Aliasing: train PC 0x40, then fetch 0x40+(4<<IDX_W) -> tag mismatch, next PC = fetch PC+4, `PredTakenD`=0.

Source files
------------

// File: rtl/fetch_predict_stage_pkg.sv
// Shared definitions for the fetch/predict stage: predictor sizing,
// 2-bit counter encodings and the counter update rule.
package fetch_predict_stage_pkg;

  localparam int IDX_W_DEF = 6;

  typedef enum logic [1:0] {
    CNT_SNT = 2'd0,
    CNT_WNT = 2'd1,
    CNT_WT  = 2'd2,
    CNT_ST  = 2'd3
  } bht_cnt_e;

  localparam bht_cnt_e    CNT_RESET = CNT_WNT;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Saturating step of a 2-bit direction counter.
  function automatic bht_cnt_e cnt_next(input bht_cnt_e c, input logic taken);
    bht_cnt_e n;
    n = c;
    case (c)
      CNT_SNT: n = taken ? CNT_WNT : CNT_SNT;
      CNT_WNT: n = taken ? CNT_WT  : CNT_SNT;
      CNT_WT:  n = taken ? CNT_ST  : CNT_WNT;
      CNT_ST:  n = taken ? CNT_ST  : CNT_WT;
      default: n = CNT_RESET;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/fetch_predict_stage_branch_predictor.sv
// Direct-mapped branch predictor: 2-bit BHT plus tagged BTB, all in flops.
// One combinational lookup port, one synchronous training port. A lookup
// and an update to the same entry in one cycle: lookup sees the old state.
module fetch_predict_stage_branch_predictor
  import fetch_predict_stage_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:2] lookup_pc,
  output logic        lookup_taken,
  output logic [31:0] lookup_target,
  input  logic        upd_en,
  input  logic [31:2] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target
);

  localparam int N     = 1 << IDX_W;
  localparam int TAG_W = 30 - IDX_W;

  bht_cnt_e           cnt_q [N];
  logic               vld_q [N];
  logic [TAG_W-1:0]   tag_q [N];
  logic [31:0]        tgt_q [N];

  logic [IDX_W-1:0]   lk_idx;
  logic [IDX_W-1:0]   up_idx;
  logic [TAG_W-1:0]   lk_tag;
  logic [TAG_W-1:0]   up_tag;
  logic               lk_hit;

  assign lk_idx = lookup_pc[IDX_W+1:2];
  assign lk_tag = lookup_pc[31:IDX_W+2];
  assign up_idx = upd_pc[IDX_W+1:2];
  assign up_tag = upd_pc[31:IDX_W+2];

  assign lk_hit        = vld_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign lookup_taken  = lk_hit && (cnt_q[lk_idx] >= CNT_WT);
  assign lookup_target = tgt_q[lk_idx];

  // Direction counters and valid bits: cleared on reset, trained on update.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= CNT_RESET;
        vld_q[i] <= 1'b0;
      end
    end else if (upd_en) begin
      cnt_q[up_idx] <= cnt_next(cnt_q[up_idx], upd_taken);
      if (upd_taken) vld_q[up_idx] <= 1'b1;
    end
  end

  // BTB tag/target written only by taken updates; meaningless while invalid.
  always_ff @(posedge clk) begin
    if (rst && upd_en && upd_taken) begin
      tag_q[up_idx] <= up_tag;
      tgt_q[up_idx] <= upd_target;
    end
  end

endmodule

// File: rtl/fetch_predict_stage.sv
// Instruction-fetch stage: PC register, next-PC selection using the branch
// predictor, and the IF/ID pipeline register feeding decode.
// Interface protocol: there is no valid/ready handshake; StallF, StallD,
// FlushD and RedirectE are levels sampled on every rising edge, and the
// IF/ID outputs are always meaningful (a flushed slot reads as all zeros).
module fetch_predict_stage
  import fetch_predict_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IDX_W    = IDX_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] PCF,
  input  logic [31:0] InstrF,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        UpdateE,
  input  logic [31:0] UpdatePCE,
  input  logic        UpdateTakenE,
  input  logic [31:0] UpdateTargetE,
  input  logic        RedirectE,
  input  logic [31:0] RedirectPCE,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        PredTakenD,
  output logic [31:0] PredTargetD
);

  logic        pred_taken;
  logic [31:0] btb_target;
  logic [31:0] pc_plus4;
  logic [31:0] pred_next;
  logic [31:0] pc_next;
  logic        unused_upd_lsb;

  // Word-aligned instructions: the low PC bits never reach the predictor.
  assign unused_upd_lsb = ^UpdatePCE[1:0];

  fetch_predict_stage_branch_predictor #(
    .IDX_W (IDX_W)
  ) u_branch_predictor (
    .clk           (clk),
    .rst           (rst),
    .lookup_pc     (PCF[31:2]),
    .lookup_taken  (pred_taken),
    .lookup_target (btb_target),
    .upd_en        (UpdateE),
    .upd_pc        (UpdatePCE[31:2]),
    .upd_taken     (UpdateTakenE),
    .upd_target    (UpdateTargetE)
  );

  assign pc_plus4  = PCF + 32'd4;
  assign pred_next = pred_taken ? btb_target : pc_plus4;

  // Next-PC priority: redirect from EX, then fetch stall, then prediction.
  always_comb begin
    pc_next = pred_next;
    if (RedirectE)   pc_next = RedirectPCE;
    else if (StallF) pc_next = PCF;
  end

  // PC register.
  always_ff @(posedge clk) begin
    if (!rst) PCF <= RESET_PC;
    else      PCF <= pc_next;
  end

  // IF/ID register: flush beats stall, otherwise capture the fetch slot.
  always_ff @(posedge clk) begin
    if (!rst || FlushD) begin
      InstrD      <= '0;
      PCD         <= '0;
      PCPlus4D    <= '0;
      PredTakenD  <= 1'b0;
      PredTargetD <= '0;
    end else if (!StallD) begin
      InstrD      <= InstrF;
      PCD         <= PCF;
      PCPlus4D    <= pc_plus4;
      PredTakenD  <= pred_taken;
      PredTargetD <= pred_next;
    end
  end

endmodule

// File: tb/tb_fetch_predict_stage.sv
// Directed bench for fetch_predict_stage: a driver applies one vector per
// cycle and queues the state expected after that edge; a monitor pops and
// compares every output after each rising edge.
module tb_fetch_predict_stage;

  logic        clk;
  logic        rst;
  logic [31:0] PCF;
  logic [31:0] InstrF;
  logic        StallF, StallD, FlushD;
  logic        UpdateE, UpdateTakenE, RedirectE;
  logic [31:0] UpdatePCE, UpdateTargetE, RedirectPCE;
  logic [31:0] InstrD, PCD, PCPlus4D, PredTargetD;
  logic        PredTakenD;

  typedef struct packed {
    logic [7:0]  id;
    logic [31:0] pcf;
    logic [31:0] instr;
    logic [31:0] pcd;
    logic [31:0] p4;
    logic        pt;
    logic [31:0] tgt;
  } exp_t;

  localparam int EXP_W = $bits(exp_t);
  logic [EXP_W-1:0] exp_q[$];

  int n_vec  = 0;
  int n_miss = 0;
  int vec_id = 0;

  // Instruction memory model: contents derived from the address.
  function automatic logic [31:0] imem(input logic [31:0] pc);
    return pc ^ 32'h1357_0000;
  endfunction

  assign InstrF = imem(PCF);

  fetch_predict_stage #(
    .RESET_PC (32'h0000_0100),
    .IDX_W    (6)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .PCF           (PCF),
    .InstrF        (InstrF),
    .StallF        (StallF),
    .StallD        (StallD),
    .FlushD        (FlushD),
    .UpdateE       (UpdateE),
    .UpdatePCE     (UpdatePCE),
    .UpdateTakenE  (UpdateTakenE),
    .UpdateTargetE (UpdateTargetE),
    .RedirectE     (RedirectE),
    .RedirectPCE   (RedirectPCE),
    .InstrD        (InstrD),
    .PCD           (PCD),
    .PCPlus4D      (PCPlus4D),
    .PredTakenD    (PredTakenD),
    .PredTargetD   (PredTargetD)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: apply inputs on the falling edge, queue the post-edge state.
  task automatic vec(input logic r, sf, sd, fd, ue, utk, re,
                     input logic [31:0] upc, utg, rpc,
                     input logic [31:0] e_pcf, e_ins, e_pcd, e_p4, e_tgt,
                     input logic e_pt);
    exp_t e;
    @(negedge clk);
    rst = r; StallF = sf; StallD = sd; FlushD = fd;
    UpdateE = ue; UpdateTakenE = utk; UpdatePCE = upc; UpdateTargetE = utg;
    RedirectE = re; RedirectPCE = rpc;
    vec_id++;
    e.id = vec_id[7:0];
    e.pcf = e_pcf; e.instr = e_ins; e.pcd = e_pcd; e.p4 = e_p4;
    e.pt = e_pt; e.tgt = e_tgt;
    exp_q.push_back(EXP_W'(e));
  endtask

  task automatic chk32(input logic [7:0] id, input string nm,
                       input logic [31:0] act, input logic [31:0] req);
    if (act !== req) begin
      n_miss++;
      $display("FAIL vec%0d %s: got %h, expected %h", id, nm, act, req);
    end
  endtask

  // Monitor / scoreboard: compare everything one step after each rising edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_t'(exp_q.pop_front());
      n_vec++;
      chk32(e.id, "PCF",         PCF,               e.pcf);
      chk32(e.id, "InstrD",      InstrD,            e.instr);
      chk32(e.id, "PCD",         PCD,               e.pcd);
      chk32(e.id, "PCPlus4D",    PCPlus4D,          e.p4);
      chk32(e.id, "PredTakenD",  {31'd0, PredTakenD}, {31'd0, e.pt});
      chk32(e.id, "PredTargetD", PredTargetD,       e.tgt);
    end
  end

  initial begin
    rst = 1'b0; StallF = 0; StallD = 0; FlushD = 0;
    UpdateE = 0; UpdateTakenE = 0; UpdatePCE = '0; UpdateTargetE = '0;
    RedirectE = 0; RedirectPCE = '0;

    //  r sf sd fd ue utk re  upc      utg      rpc        PCF           InstrD              PCD           PCPlus4D      PredTarget    PT
    // reset held two cycles
    vec(0,0,0,0, 0,0,0, 32'h0,  32'h0,  32'h0,       32'h100,      32'h0,              32'h0,        32'h0,        32'h0,        0);
    vec(0,0,0,0, 0,0,0, 32'h0,  32'h0,  32'h0,       32'h100,      32'h0,              32'h0,        32'h0,        32'h0,        0);
    // sequential fetch out of reset
    vec(1,0,0,0, 0,0,0, 32'h0,  32'h0,  32'h0,       32'h104,      imem(32'h100),      32'h100,      32'h104,      32'h104,      0);
    vec(1,0,0,0, 0,0,0, 32'h0,  32'h0,  32'h0,       32'h108,      imem(32'h104),      32'h104,      32'h108,      32'h108,      0);
    // train 0x40 taken -> 0x80 twice (counter 1->2->3), redirect to 0x40 with flush
    vec(1,0,0,0, 1,1,0, 32'h40, 32'h80, 32'h0,       32'h10C,      imem(32'h108),      32'h108,      32'h10C,      32'h10C,      0);
    vec(1,0,0,1, 1,1,1, 32'h40, 32'h80, 32'h40,      32'h40,       32'h0,              32'h0,        32'h0,        32'h0,        0);
    vec(1,0,0,0, 0,0,0, 32'h0,  32'h0,  32'h0,       32'h80,       imem(32'h40),       32'h40,       32'h44,       32'h80,       1);
    // hysteresis: one not-taken -> counter 2, still taken
    vec(1,0,0,1, 1,0,1, 32'h40, 32'h0,  32'h40,      32'h40,       32'h0,              32'h0,        32'h0,        32'h0,        0);
    vec(1,0,0,0, 0,0,0, 32'h0,  32'h0,  32'h0,       32'h80,       imem(32'h40),       32'h40,       32'h44,       32'h80,       1);
    // second not-taken -> counter 1, falls through
    vec(1,0,0,1, 1,0,1, 32'h40, 32'h0,  32'h40,      32'h40,       32'h0,              32'h0,        32'h0,        32'h0,        0);
    vec(1,0,0,0, 0,0,0, 32'h0,  32'h0,  32'h0,       32'h44,       imem(32'h40),       32'h40,       32'h44,       32'h44,       0);
    // same-cycle lookup/update: taken -> counter 2; then lookup sees 2 while update drops it to 1
    vec(1,0,0,1, 1,1,1, 32'h40, 32'h80, 32'h40,      32'h40,       32'h0,              32'h0,        32'h0,        32'h0,        0);
    vec(1,0,0,0, 1,0,0, 32'h40, 32'h0,  32'h0,       32'h80,       imem(32'h40),       32'h40,       32'h44,       32'h80,       1);
    vec(1,0,0,1, 0,0,1, 32'h0,  32'h0,  32'h40,      32'h40,       32'h0,              32'h0,        32'h0,        32'h0,        0);
    vec(1,0,0,0, 0,0,0, 32'h0,  32'h0,  32'h0,       32'h44,       imem(32'h40),       32'h40,       32'h44,       32'h44,       0);
    // retrain 0x40 to strongly taken
    vec(1,0,0,0, 1,1,0, 32'h40, 32'h80, 32'h0,       32'h48,       imem(32'h44),       32'h44,       32'h48,       32'h48,       0);
    vec(1,0,0,0, 1,1,0, 32'h40, 32'h80, 32'h0,       32'h4C,       imem(32'h48),       32'h48,       32'h4C,       32'h4C,       0);
    // aliasing: 0x140 shares index with 0x40, tag mismatch -> no prediction
    vec(1,0,0,1, 0,0,1, 32'h0,  32'h0,  32'h140,     32'h140,      32'h0,              32'h0,        32'h0,        32'h0,        0);
    vec(1,0,0,0, 0,0,0, 32'h0,  32'h0,  32'h0,       32'h144,      imem(32'h140),      32'h140,      32'h144,      32'h144,      0);
    // redirect beats StallF; StallD holds D for several cycles
    vec(1,1,1,0, 0,0,1, 32'h0,  32'h0,  32'h200,     32'h200,      imem(32'h140),      32'h140,      32'h144,      32'h144,      0);
    vec(1,1,1,0, 0,0,0, 32'h0,  32'h0,  32'h0,       32'h200,      imem(32'h140),      32'h140,      32'h144,      32'h144,      0);
    vec(1,1,1,0, 0,0,0, 32'h0,  32'h0,  32'h0,       32'h200,      imem(32'h140),      32'h140,      32'h144,      32'h144,      0);
    vec(1,1,1,0, 0,0,0, 32'h0,  32'h0,  32'h0,       32'h200,      imem(32'h140),      32'h140,      32'h144,      32'h144,      0);
    // flush overrides stall
    vec(1,1,1,1, 0,0,0, 32'h0,  32'h0,  32'h0,       32'h200,      32'h0,              32'h0,        32'h0,        32'h0,        0);
    vec(1,0,0,0, 0,0,0, 32'h0,  32'h0,  32'h0,       32'h204,      imem(32'h200),      32'h200,      32'h204,      32'h204,      0);
    // 32-bit wraparound of PC+4
    vec(1,0,0,1, 0,0,1, 32'h0,  32'h0,  32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0,           32'h0,        32'h0,        32'h0,        0);
    vec(1,0,0,0, 0,0,0, 32'h0,  32'h0,  32'h0,       32'h0,        imem(32'hFFFF_FFFC), 32'hFFFF_FFFC, 32'h0,      32'h0,        0);
    // mid-operation reset overrides redirect/training; predictor cleared
    vec(0,0,0,0, 1,1,1, 32'h40, 32'h80, 32'h300,     32'h100,      32'h0,              32'h0,        32'h0,        32'h0,        0);
    vec(1,0,0,1, 0,0,1, 32'h0,  32'h0,  32'h40,      32'h40,       32'h0,              32'h0,        32'h0,        32'h0,        0);
    vec(1,0,0,0, 0,0,0, 32'h0,  32'h0,  32'h0,       32'h44,       imem(32'h40),       32'h40,       32'h44,       32'h44,       0);

    // Drain: bounded wait for the monitor to consume all expectations.
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
